// File: rtl/y86_alu_pkg.sv
// rtl/y86_alu_pkg.sv - shared constants for the Y86-64 pipelined ALU
package y86_alu_pkg;

  // Function codes carried on in_fun
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SHL = 4'd4;
  localparam logic [3:0] ALU_SHR = 4'd5;
  localparam logic [3:0] ALU_SAR = 4'd6;

  // Bit positions inside the 3-bit {ZF, SF, OF} flag vectors
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Condition codes out of reset: zero flag set, as after a zero result
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu_pipe_core.sv
// rtl/y86_alu_pipe_core.sv - combinational ALU datapath; shifts only with Y86_ALU_SHIFT_EN
module y86_alu_core
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             err
);

`ifdef Y86_ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
`endif

  logic ovf;

  // Compute result, signed overflow and flags; unknown codes yield zero with err
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = a + ~b + WIDTH'(1);
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
`ifdef Y86_ALU_SHIFT_EN
      ALU_SHL: result = a << b[SHW-1:0];
      ALU_SHR: result = a >> b[SHW-1:0];
      ALU_SAR: result = $unsigned($signed(a) >>> b[SHW-1:0]);
`endif
      default: err = 1'b1;
    endcase
    flags        = '0;
    flags[CC_ZF] = (result == '0);
    flags[CC_SF] = result[WIDTH-1];
    flags[CC_OF] = ovf;
  end

endmodule

// File: rtl/y86_alu_pipe.sv
// rtl/y86_alu_pipe.sv - two-stage pipelined Y86-64 ALU with CC register (optional Y86_ALU_SHIFT_EN)
module y86_alu_pipe
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fun,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [2:0]       out_flags,
  output logic             out_err,
  output logic [2:0]       cc
);

  logic             s1_valid;
  logic [3:0]       s1_fun;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_set_cc;
  logic             s2_set_cc;
  logic             s2_ready;
  logic [WIDTH-1:0] core_result;
  logic [2:0]       core_flags;
  logic             core_err;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = (!s1_valid || s2_ready) && !flush;

  y86_alu_core #(.WIDTH(WIDTH)) u_core (
    .fun    (s1_fun),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result),
    .flags  (core_flags),
    .err    (core_err)
  );

  // Stage 1: capture the accepted operation; flush empties the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fun    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_set_cc <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fun    <= in_fun;
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_set_cc <= in_set_cc;
      end
    end
  end

  // Stage 2: register the core result; held unchanged while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_val   <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
      s2_set_cc <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_val   <= core_result;
        out_flags <= core_flags;
        out_err   <= core_err;
        s2_set_cc <= s1_set_cc;
      end
    end
  end

  // Architectural CC: updated only when a valid, CC-setting op retires (even in a flush cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (out_valid && out_ready && s2_set_cc && !out_err) begin
      cc <= out_flags;
    end
  end

endmodule

// File: tb/tb_y86_alu_pipe.sv
// tb/tb_y86_alu_pipe.sv - self-checking bench for y86_alu_pipe against a behavioural model
module tb_y86_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_fun;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_set_cc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_val;
  logic [2:0]  out_flags;
  logic        out_err;
  logic [2:0]  cc;

  y86_alu_pipe #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fun    (in_fun),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_set_cc (in_set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_flags (out_flags),
    .out_err   (out_err),
    .cc        (cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    logic [2:0]  flags;
    logic        err;
    logic        set_cc;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic [2:0] cc_m;
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result from signed/unsigned arithmetic on the operands
  function automatic exp_t model(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input int acc);
    exp_t        e;
    logic [64:0] wide;
    logic        of;
    e.val = 64'd0; e.err = 1'b0; e.set_cc = s; e.acc = acc; of = 1'b0;
    case (f)
      4'd0: begin wide = {a[63], a} + {b[63], b}; e.val = wide[63:0]; of = wide[64] ^ wide[63]; end
      4'd1: begin wide = {a[63], a} - {b[63], b}; e.val = wide[63:0]; of = wide[64] ^ wide[63]; end
      4'd2: e.val = a & b;
      4'd3: e.val = a ^ b;
`ifdef Y86_ALU_SHIFT_EN
      4'd4: e.val = a << b[5:0];
      4'd5: e.val = a >> b[5:0];
      4'd6: e.val = $unsigned($signed(a) >>> b[5:0]);
`endif
      default: e.err = 1'b1;
    endcase
    e.flags = e.err ? 3'b100 : {e.val == 64'd0, e.val[63], of};
    return e;
  endfunction

  task automatic set_in(input logic v, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic s);
    in_valid = v; in_fun = f; in_a = a; in_b = b; in_set_cc = s;
  endtask

  // One clock: called at posedge+1 with inputs set; checks at negedge, advances the model at posedge
  task automatic cycle();
    logic exp_in_ready, exp_out_valid, in_hs, out_hs;
    #4;
    exp_in_ready  = !flush && (q.size() < 2 || out_ready);
    exp_out_valid = (q.size() > 0) && (edge_n > q[0].acc);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_in_ready});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_out_valid});
    chk("cc", {61'd0, cc}, {61'd0, cc_m});
    if (exp_out_valid) begin
      chk("out_val", out_val, q[0].val);
      chk("out_flags", {61'd0, out_flags}, {61'd0, q[0].flags});
      chk("out_err", {63'd0, out_err}, {63'd0, q[0].err});
    end
    in_hs  = in_valid && exp_in_ready;
    out_hs = exp_out_valid && out_ready;
    @(posedge clk);
    edge_n++;
    if (out_hs) begin
      if (q[0].set_cc && !q[0].err) cc_m = q[0].flags;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (in_hs) q.push_back(model(in_fun, in_a, in_b, in_set_cc, edge_n));
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0: r = 64'h7FFF_FFFF_FFFF_FFFF;
      1: r = 64'h8000_0000_0000_0000;
      2: r = 64'd0;
      3: r = 64'(($urandom_range(0, 70)));
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; cc_m = 3'b100;
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_val", out_val, 64'd0);
    chk("rst_out_flags", {61'd0, out_flags}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_cc", {61'd0, cc}, 64'd4);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow with set_cc
    set_in(1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    cycle();
    chk("add_of_val", out_val, 64'h8000_0000_0000_0000);
    chk("add_of_flags", {61'd0, out_flags}, 64'd3);
    cycle();
    chk("add_of_cc", {61'd0, cc}, 64'd3);

    // SUB 5-5 without set_cc
    set_in(1'b1, 4'd1, 64'd5, 64'd5, 1'b0);
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    cycle();
    chk("sub_zero_val", out_val, 64'd0);
    chk("sub_zero_flags", {61'd0, out_flags}, 64'd4);
    cycle();
    chk("sub_zero_cc", {61'd0, cc}, 64'd3);

    // Back-to-back ADD, AND, XOR with the consumer stalled for three cycles
    out_ready = 1'b0;
    set_in(1'b1, 4'd0, 64'd10, 64'd20, 1'b1);
    cycle();
    set_in(1'b1, 4'd2, 64'hF0F0, 64'hFF00, 1'b1);
    cycle();
    set_in(1'b1, 4'd3, 64'hAAAA, 64'h5555, 1'b1);
    #1 chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    repeat (4) cycle();
    chk("bp_drained_cc", {61'd0, cc}, 64'd0);

    // Flush with two ops in flight
    out_ready = 1'b0;
    set_in(1'b1, 4'd0, 64'd1, 64'd1, 1'b1);
    cycle();
    set_in(1'b1, 4'd1, 64'd1, 64'd2, 1'b1);
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_cc", {61'd0, cc}, 64'd0);
    out_ready = 1'b1;
    set_in(1'b1, 4'd3, 64'd7, 64'd2, 1'b0);
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    cycle();
    chk("post_flush_valid", {63'd0, out_valid}, 64'd1);
    chk("post_flush_val", out_val, 64'd5);
    cycle();

    // Function code 4 / SAR
`ifdef Y86_ALU_SHIFT_EN
    set_in(1'b1, 4'd6, 64'h8000_0000_0000_0000, 64'd4, 1'b1);
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    cycle();
    chk("sar_val", out_val, 64'hF800_0000_0000_0000);
    cycle();
`else
    set_in(1'b1, 4'd4, 64'h1234, 64'd4, 1'b1);
    cycle();
    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    cycle();
    chk("fun4_err", {63'd0, out_err}, 64'd1);
    chk("fun4_val", out_val, 64'd0);
    cycle();
    chk("fun4_cc", {61'd0, cc}, 64'd0);
`endif

    // Randomised traffic with one asynchronous reset mid-stream
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) != 0, 4'($urandom_range(0, 9)), rnd64(), rnd64(), 1'($urandom));
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      if (i == 200) begin
        flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_cc", {61'd0, cc}, 64'd4);
        q.delete();
        cc_m = 3'b100;
        set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
        @(posedge clk);
        edge_n++;
        #1 rst_n = 1'b1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      end
      cycle();
    end

    set_in(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    flush = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_alu_pipe.md
# y86_alu_pipe

Parametrised, two-stage pipelined integer ALU for the Y86-64 execute stage, successor to the single-cycle combinational 64-bit ALU. Accepts one operation per cycle over a valid/ready handshake, registers operands and result, and maintains the architectural condition-code register (ZF, SF, OF). It sits between decode and memory stages and supports flush on branch mispredict.

## Interface
- WIDTH, 64, operand/result width in bits; 8 or more, power of two.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_fun  in  4  function code: 0 ADD, 1 SUB, 2 AND, 3 XOR; 4 SHL, 5 SHR, 6 SAR only with the macro.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_set_cc  in  1  operation updates the CC register on retire.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_val  out  WIDTH  result.
- out_flags  out  3  {ZF, SF, OF} of this result.
- out_err  out  1  in_fun was undefined.
- cc  out  3  architectural {ZF, SF, OF} register.

## Operation
- ADD: A+B. SUB: A-B (A + ~B + 1). AND: A&B. XOR: A^B. All results modulo 2^WIDTH.
- ZF = (result == 0). SF = result[WIDTH-1].
- OF, ADD: A[msb]==B[msb] && result[msb]!=A[msb]. OF, SUB: A[msb]!=B[msb] && result[msb]!=A[msb]. OF = 0 for logic and shift ops.
- Undefined in_fun: out_val = 0, out_flags = {1,0,0}, out_err = 1; still consumes a slot; CC never updated regardless of set_cc.
- Stage 1 (S1): registers fun, A, B, set_cc, valid. Stage 2 (S2): registers result, flags, err, set_cc, valid; drives out_*.
- CC register updates from out_flags on output handshake when the retiring op has set_cc=1 and err=0; otherwise holds.
- Backpressure: s2_ready = !out_valid || out_ready; S1 advances when s2_ready; in_ready = (!s1_valid || s2_ready) && !flush.
- flush: S1 and S2 valid cleared at the edge; an op handshaking out in the flush cycle still retires (updates CC); no input accepted that cycle.

## Timing
- Latency 2 cycles: op accepted at edge N appears on out_* after edge N+1; throughput 1 op/cycle with out_ready held high.
- Reset values: in_ready 1, out_valid 0, out_val 0, out_flags 0, out_err 0, cc 3'b100 (ZF set).
- Reset mid-operation discards all in-flight ops immediately (asynchronous); no CC update.
- out_val/out_flags/out_err stable while out_valid && !out_ready.
- Simultaneous output handshake and new input with full pipeline: both occur, no bubble.

## Configuration
- Y86_ALU_SHIFT_EN defined: fun 4 SHL (A << B[log2 WIDTH-1:0]), 5 SHR logical, 6 SAR arithmetic; OF = 0.
- Not defined: fun 4-6 treated as undefined (out_err = 1, result 0); no shifter logic synthesised.

## Structure
- Shared package y86_alu_pkg: function code constants (ALU_ADD..ALU_SAR), flag bit indices (CC_ZF=2, CC_SF=1, CC_OF=0), CC reset constant.
- One sub-module: y86_alu_core, purely combinational (fun, A, B -> result, flags, err), instantiated between S1 and S2.

## Test plan
- Reset: rst_n low mid-stream -> out_valid 0, cc 3'b100, in_ready 1 on release.
- WIDTH=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1 with set_cc -> out_val 0x8000_0000_0000_0000, flags {0,1,1}, cc {0,1,1} after handshake.
- SUB 5 - 5 with set_cc=0 -> out_val 0, flags {1,0,0}, cc unchanged.
- Back-to-back ADD, AND, XOR with out_ready low 3 cycles -> in_ready drops after 2 accepted, results emitted in order, none lost or duplicated.
- flush with two ops in flight -> out_valid 0 next cycle, cc unchanged, next accepted op appears 2 cycles later.
- fun 4 without macro -> out_err 1, out_val 0, cc unchanged; with macro, SAR 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000.
